// File: rtl/frame_capture_ctrl_if.sv
// rtl/frame_capture_ctrl_if.sv - processed pixel stream in, frame buffer write port out
interface frame_capture_ctrl_if #(
  parameter int ADDR_W = 21
) ();
  logic              in_vsync;
  logic              in_href;
  logic [7:0]        in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    output in_vsync, in_href, in_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_vsync, in_href, in_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - captures one selected frame into a byte-addressed frame buffer
module frame_capture_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 21,
  parameter int FRAME_SEL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_capture_ctrl_if.slave  bus,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [3:0]           progress_o,
  output logic                 progress_stb_o,
  output logic                 err_line_o,
  output logic                 err_frame_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;

  localparam int                CNT_W     = 16;
  localparam logic [CNT_W-1:0]  W_C       = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0]  H_C       = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0]  STEP_C    = CNT_W'(10);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(3 * IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3);
  localparam logic [7:0]        SEL_C     = 8'(FRAME_SEL);

  state_t             state_q, state_d;
  logic               vs_q, hr_q;
  logic [7:0]         frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [23:0]        wr_data_q, wr_data_d;
  logic [3:0]         progress_q, progress_d;
  logic               prog_stb_q, prog_stb_d;
  logic               err_line_q, err_line_d;
  logic               err_frame_q, err_frame_d;

  logic               vs_rise;
  logic               line_end;
  logic [CNT_W-1:0]   acc_sum;

  // State and datapath registers; reset aborts any capture in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      frm_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      acc_q       <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      progress_q  <= '0;
      prog_stb_q  <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= bus.in_vsync;
      hr_q        <= bus.in_href;
      frm_cnt_q   <= frm_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      progress_q  <= progress_d;
      prog_stb_q  <= prog_stb_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  // Next-state: frame selection, pixel-to-write conversion, line/frame geometry and progress
  always_comb begin
    state_d     = state_q;
    frm_cnt_d   = frm_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    progress_d  = progress_q;
    prog_stb_d  = 1'b0;
    err_line_d  = err_line_q;
    err_frame_d = err_frame_q;

    vs_rise  = bus.in_vsync & ~vs_q;
    // A line closes on href fall, or when vsync cuts an open line short
    line_end = (state_q == S_CAPTURE) && hr_q && (!bus.in_href || vs_rise);
    acc_sum  = acc_q + STEP_C;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_WAIT_VS;
          frm_cnt_d   = '0;
          err_line_d  = 1'b0;
          err_frame_d = 1'b0;
          progress_d  = '0;
        end
      end

      S_WAIT_VS: begin
        if (vs_rise) begin
          frm_cnt_d = frm_cnt_q + 8'd1;
          if (frm_cnt_d == SEL_C) begin
            state_d    = S_CAPTURE;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            addr_d     = '0;
            acc_d      = '0;
          end
        end
      end

      S_CAPTURE: begin
        if (line_end) begin
          if (pix_cnt_q != W_C) err_line_d = 1'b1;
          pix_cnt_d  = '0;
          line_cnt_d = line_cnt_q + 1'b1;
          // Fractional accumulator: one progress step per IMG_H/10 lines
          if (acc_sum >= H_C) begin
            acc_d = acc_sum - H_C;
            if (progress_q != 4'd10) begin
              progress_d = progress_q + 4'd1;
              prog_stb_d = 1'b1;
            end
          end else begin
            acc_d = acc_sum;
          end
        end

        if (vs_rise) begin
          // The pixel coinciding with the closing vsync is dropped
          if (line_cnt_d != H_C) err_frame_d = 1'b1;
          state_d = S_DONE;
        end else if (bus.in_href) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (addr_q < ADDR_LIM) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {3{bus.in_data}};
            addr_d    = addr_q + ADDR_STEP;
          end else begin
            err_frame_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy_o         = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
  assign done_o         = (state_q == S_DONE);
  assign progress_o     = progress_q;
  assign progress_stb_o = prog_stb_q;
  assign err_line_o     = err_line_q;
  assign err_frame_o    = err_frame_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - directed table-driven bench for frame_capture_ctrl
module tb_frame_capture_ctrl;
  localparam int W  = 8;
  localparam int H  = 10;
  localparam int AW = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vs = 1'b0, hr = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       start_a = 1'b0, start_b = 1'b0;

  logic       busy_a, done_a, stb_a, el_a, ef_a;
  logic [3:0] prog_a;
  logic       busy_b, done_b, stb_b, el_b, ef_b;
  logic [3:0] prog_b;

  frame_capture_ctrl_if #(.ADDR_W(AW)) bus_a ();
  frame_capture_ctrl_if #(.ADDR_W(AW)) bus_b ();

  assign bus_a.in_vsync = vs;
  assign bus_a.in_href  = hr;
  assign bus_a.in_data  = dat;
  assign bus_b.in_vsync = vs;
  assign bus_b.in_href  = hr;
  assign bus_b.in_data  = dat;

  frame_capture_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FRAME_SEL(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .progress_o(prog_a), .progress_stb_o(stb_a),
    .err_line_o(el_a), .err_frame_o(ef_a)
  );

  frame_capture_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FRAME_SEL(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .progress_o(prog_b), .progress_stb_o(stb_b),
    .err_line_o(el_b), .err_frame_o(ef_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         t;
  } px_t;

  typedef struct {
    int         lines;
    int         short_ln;
    int         short_len;
    logic [7:0] base;
    int         exp_wr;
    bit         exp_el;
    bit         exp_ef;
    int         exp_prog;
    int         exp_stb;
  } vec_t;

  px_t  exp_q[$];
  px_t  e;
  vec_t vecs[4];
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  int   wr_idx_a = 0, wr_idx_b = 0, stb_cnt = 0, pushed = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d expected %0d", name, got, want);
  endtask

  // Cycle counter used to verify one-clock input-to-write latency
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the FRAME_SEL=1 instance
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.wr_en) begin
        if (exp_q.size() == 0) begin
          chk("a_wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("a_wr_addr", int'(bus_a.wr_addr), 3 * wr_idx_a);
          chk("a_wr_data", int'(bus_a.wr_data), int'({e.d, e.d, e.d}));
          chk("a_wr_time", cyc, e.t);
          wr_idx_a++;
        end
      end
      if (stb_a) stb_cnt++;
    end
  end

  // Scoreboard for the FRAME_SEL=2 instance: only the 0x22 frame may land
  always @(negedge clk) begin
    if (!rst && bus_b.wr_en) begin
      chk("b_wr_data", int'(bus_b.wr_data), 32'h00222222);
      chk("b_wr_addr", int'(bus_b.wr_addr), 3 * wr_idx_b);
      wr_idx_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_px(input logic [7:0] d, input bit cap);
    px_t p;
    if (cap && pushed < W * H) begin
      p.d = d;
      p.t = cyc + 1;
      exp_q.push_back(p);
      pushed++;
    end
  endtask

  task automatic vsync_pulse();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drive_frame(input int lines, input int short_ln, input int short_len,
                             input logic [7:0] base, input bit ramp, input bit cap);
    int k;
    int len;
    k = 0;
    for (int l = 0; l < lines; l++) begin
      len = (l == short_ln) ? short_len : W;
      for (int i = 0; i < len; i++) begin
        hr  = 1'b1;
        dat = ramp ? 8'(base + 8'(k)) : base;
        k++;
        push_px(dat, cap);
        tick();
      end
      hr  = 1'b0;
      dat = 8'h00;
      repeat (2) tick();
    end
  endtask

  task automatic start_a_pulse();
    exp_q.delete();
    pushed   = 0;
    wr_idx_a = 0;
    stb_cnt  = 0;
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    chk("start_busy", int'(busy_a), 1);
    chk("start_done_clr", int'(done_a), 0);
    chk("start_prog_clr", int'(prog_a), 0);
    chk("start_el_clr", int'(el_a), 0);
    chk("start_ef_clr", int'(ef_a), 0);
  endtask

  task automatic check_end(input string tag, input int wr, input bit el, input bit ef,
                           input int pr, input int sb);
    chk({tag, "_done"}, int'(done_a), 1);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_writes"}, wr_idx_a, wr);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_err_line"}, int'(el_a), int'(el));
    chk({tag, "_err_frame"}, int'(ef_a), int'(ef));
    chk({tag, "_progress"}, int'(prog_a), pr);
    chk({tag, "_strobes"}, stb_cnt, sb);
  endtask

  initial begin
    vecs[0] = '{10, -1, 8, 8'h00, 80, 1'b0, 1'b0, 10, 10};
    vecs[1] = '{10,  3, 7, 8'h20, 79, 1'b1, 1'b0, 10, 10};
    vecs[2] = '{11, -1, 8, 8'h80, 80, 1'b0, 1'b1, 10, 10};
    vecs[3] = '{ 9, -1, 8, 8'hA0, 72, 1'b0, 1'b1,  9,  9};

    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_prog_a", int'(prog_a), 0);
    chk("rst_stb_a", int'(stb_a), 0);
    chk("rst_err_a", int'({el_a, ef_a}), 0);
    chk("rst_wr_en_a", int'(bus_a.wr_en), 0);
    chk("rst_wr_addr_a", int'(bus_a.wr_addr), 0);
    chk("rst_wr_data_a", int'(bus_a.wr_data), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_done_b", int'(done_b), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Whole-frame scenarios from the vector table
    foreach (vecs[v]) begin
      start_a_pulse();
      vsync_pulse();
      chk("tbl_capturing", int'(busy_a), 1);
      drive_frame(vecs[v].lines, vecs[v].short_ln, vecs[v].short_len, vecs[v].base, 1'b1, 1'b1);
      chk("tbl_not_done_early", int'(done_a), 0);
      vsync_pulse();
      check_end($sformatf("tbl%0d", v), vecs[v].exp_wr, vecs[v].exp_el, vecs[v].exp_ef,
                vecs[v].exp_prog, vecs[v].exp_stb);
    end

    // FRAME_SEL=2: frames 0x11 / 0x22 / 0x33, only the second is written
    wr_idx_b = 0;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    vsync_pulse();
    drive_frame(10, -1, 8, 8'h11, 1'b0, 1'b0);
    chk("sel2_skip_busy", int'(busy_b), 1);
    chk("sel2_skip_writes", wr_idx_b, 0);
    vsync_pulse();
    drive_frame(10, -1, 8, 8'h22, 1'b0, 1'b0);
    vsync_pulse();
    chk("sel2_done", int'(done_b), 1);
    chk("sel2_writes", wr_idx_b, 80);
    drive_frame(10, -1, 8, 8'h33, 1'b0, 1'b0);
    vsync_pulse();
    chk("sel2_after_writes", wr_idx_b, 80);
    chk("sel2_err", int'({el_b, ef_b}), 0);
    chk("sel2_progress", int'(prog_b), 10);

    // Reset during line 5 of a capture
    start_a_pulse();
    vsync_pulse();
    drive_frame(4, -1, 8, 8'h00, 1'b1, 1'b1);
    chk("rstmid_prog_before", int'(prog_a), 4);
    chk("rstmid_wr_before", wr_idx_a, 32);
    hr  = 1'b1;
    dat = 8'h55;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_busy", int'(busy_a), 0);
    chk("rstmid_prog", int'(prog_a), 0);
    chk("rstmid_wr_en", int'(bus_a.wr_en), 0);
    chk("rstmid_done", int'(done_a), 0);
    hr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    drive_frame(6, -1, 8, 8'h60, 1'b1, 1'b0);
    vsync_pulse();
    chk("rstmid_idle_busy", int'(busy_a), 0);
    chk("rstmid_idle_done", int'(done_a), 0);
    chk("rstmid_no_writes", wr_idx_a, 32);
    start_a_pulse();
    vsync_pulse();
    drive_frame(10, -1, 8, 8'h10, 1'b1, 1'b1);
    vsync_pulse();
    check_end("recap", 80, 1'b0, 1'b0, 10, 10);

    // Start ignored mid-capture; vsync rises with the last line still open
    start_a_pulse();
    vsync_pulse();
    drive_frame(2, -1, 8, 8'h40, 1'b1, 1'b1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ign_start_busy", int'(busy_a), 1);
    chk("ign_start_prog", int'(prog_a), 2);
    drive_frame(7, -1, 8, 8'h50, 1'b1, 1'b1);
    for (int i = 0; i < W; i++) begin
      hr  = 1'b1;
      dat = 8'(8'h90 + 8'(i));
      push_px(dat, 1'b1);
      tick();
    end
    vs  = 1'b1;
    dat = 8'hEE;
    tick();
    hr  = 1'b0;
    tick();
    vs  = 1'b0;
    repeat (3) tick();
    check_end("openline", 80, 1'b0, 1'b0, 10, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
